// File: rtl/axi_pmp_err_slv.sv
// axi_pmp_err_slv: terminating error responder for IO-PMP denied transactions.
// Writes drain their W beats and then get one error B. Reads get arlen+1 error R
// beats that carry a fixed pattern. Saturating counters record completions.
module axi_pmp_err_slv #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          ID_WIDTH      = 8,
  parameter int          MAX_TXNS      = 4,
  parameter logic [1:0]  RESP          = 2'b10,
  parameter logic [63:0] RDATA_PATTERN = 64'hDEAD_BEEF_BADC_AB1E,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic                  w_last,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [7:0]            ar_len,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [CNT_WIDTH-1:0]  w_deny_cnt,
  output logic [CNT_WIDTH-1:0]  r_deny_cnt,
  output logic                  busy
);

  localparam int PW = (MAX_TXNS > 1) ? $clog2(MAX_TXNS) : 1;
  localparam int CW = $clog2(MAX_TXNS + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_TXNS - 1);
  localparam logic [CW-1:0] DEPTH = CW'(MAX_TXNS);
  localparam logic [DATA_WIDTH-1:0] RDATA = DATA_WIDTH'(RDATA_PATTERN);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Pointers wrap explicitly, so the depth does not have to fill the pointer width.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // ---------------- write path ----------------
  logic [ID_WIDTH-1:0] w_mem [MAX_TXNS];
  logic [PW-1:0]       w_wr_ptr, w_rd_ptr;
  logic [CW-1:0]       w_cnt, w_cnt_nxt;
  logic [1:0]          w_state;
  logic                w_push, w_pop;

  assign w_push = aw_valid && aw_ready;
  assign w_pop  = (w_state == W_RESP) && b_ready;

  // next write FIFO occupancy; a push and a pop together leave it unchanged
  always_comb begin
    w_cnt_nxt = w_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = w_cnt + CW'(1);
    else if (!w_push && w_pop) w_cnt_nxt = w_cnt - CW'(1);
  end

  // write FIFO pointers, count and registered aw_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_wr_ptr <= '0;
      w_rd_ptr <= '0;
      w_cnt    <= '0;
      aw_ready <= 1'b1;
    end else begin
      w_cnt    <= w_cnt_nxt;
      aw_ready <= (w_cnt_nxt < DEPTH);
      if (w_push) w_wr_ptr <= ptr_inc(w_wr_ptr);
      if (w_pop)  w_rd_ptr <= ptr_inc(w_rd_ptr);
    end
  end

  // write FIFO storage (contents are don't-care until pushed)
  always_ff @(posedge clk) begin
    if (w_push) w_mem[w_wr_ptr] <= aw_id;
  end

  // write FSM: wait for an AW, swallow its W beats, then answer with B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
    end else begin
      case (w_state)
        W_IDLE:  if (w_cnt != '0) w_state <= W_DATA;
        W_DATA:  if (w_valid && w_last) w_state <= W_RESP;
        W_RESP:  if (b_ready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign w_ready = (w_state == W_DATA);
  assign b_valid = (w_state == W_RESP);
  assign b_id    = b_valid ? w_mem[w_rd_ptr] : '0;
  assign b_resp  = b_valid ? RESP : 2'b00;

  // saturating count of completed denied writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          w_deny_cnt <= '0;
    else if (w_pop && ~&w_deny_cnt)   w_deny_cnt <= w_deny_cnt + CNT_WIDTH'(1);
  end

  // ---------------- read path ----------------
  logic [ID_WIDTH+7:0] r_mem [MAX_TXNS];
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_cnt, r_cnt_nxt;
  logic [0:0]          r_state;
  logic [7:0]          beat;
  logic [ID_WIDTH+7:0] r_head;
  logic [7:0]          head_len;
  logic                r_push, r_pop;

  assign r_head   = r_mem[r_rd_ptr];
  assign head_len = r_head[7:0];
  assign r_push   = ar_valid && ar_ready;
  assign r_pop    = r_valid && r_ready && r_last;

  // next read FIFO occupancy
  always_comb begin
    r_cnt_nxt = r_cnt;
    if (r_push && !r_pop)      r_cnt_nxt = r_cnt + CW'(1);
    else if (!r_push && r_pop) r_cnt_nxt = r_cnt - CW'(1);
  end

  // read FIFO pointers, count and registered ar_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      ar_ready <= 1'b1;
    end else begin
      r_cnt    <= r_cnt_nxt;
      ar_ready <= (r_cnt_nxt < DEPTH);
      if (r_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (r_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // read FIFO storage: {id, len}
  always_ff @(posedge clk) begin
    if (r_push) r_mem[r_wr_ptr] <= {ar_id, ar_len};
  end

  // read FSM: stream len+1 error beats for the head entry, then pop it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      beat    <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (r_cnt != '0) begin
          beat    <= '0;
          r_state <= R_DATA;
        end
        R_DATA: if (r_ready) begin
          if (beat == head_len) r_state <= R_IDLE;
          else                  beat    <= beat + 8'd1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign r_valid = (r_state == R_DATA);
  assign r_id    = r_valid ? r_head[ID_WIDTH+7:8] : '0;
  assign r_data  = r_valid ? RDATA : '0;
  assign r_resp  = r_valid ? RESP : 2'b00;
  assign r_last  = r_valid && (beat == head_len);

  // saturating count of completed denied reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_deny_cnt <= '0;
    else if (r_pop && ~&r_deny_cnt)   r_deny_cnt <= r_deny_cnt + CNT_WIDTH'(1);
  end

  assign busy = (w_cnt != '0) || (r_cnt != '0) || (w_state != W_IDLE) || (r_state != R_IDLE);

endmodule

// File: tb/tb_axi_pmp_err_slv.sv
// Directed bench for axi_pmp_err_slv with default parameters.
module tb_axi_pmp_err_slv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aw_id = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic        w_last = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [7:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [7:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [7:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [15:0] w_deny_cnt;
  logic [15:0] r_deny_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] PATTERN = 64'hDEADBEEFBADCAB1E;

  axi_pmp_err_slv dut (
    .clk(clk), .rst(rst),
    .aw_id(aw_id), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .w_deny_cnt(w_deny_cnt), .r_deny_cnt(r_deny_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accepts one read burst; checks every beat, stability under stall, beat count.
  task automatic rd_burst(input logic [7:0] id, input int len, input bit toggle);
    int   nb = 0;
    bit   done = 0;
    bit   stalled = 0;
    logic [7:0] pid = '0;
    logic plast = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      r_ready = toggle ? (c % 2 == 1) : 1'b1;
      if (r_valid) begin
        if (stalled) chk("r_stable", {r_id, r_last}, {pid, plast});
        chk("r_beat", {r_id, r_resp, r_last}, {id, 2'b10, (nb == len)});
        chk("r_data", r_data, PATTERN);
        if (r_ready) begin
          nb++;
          stalled = 0;
          if (r_last) done = 1;
        end else begin
          stalled = 1;
          pid = r_id;
          plast = r_last;
        end
      end
      cyc();
    end
    r_ready = 1'b0;
    chk("r_count", nb, len + 1);
  endtask

  initial begin
    int bdone;
    int rdone;

    // reset state
    #1;
    repeat (2) cyc();
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_valids", {w_ready, b_valid, r_valid}, 0);
    chk("rst_counts", {w_deny_cnt, r_deny_cnt}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_aw_ready", aw_ready, 1);
    chk("post_rst_ar_ready", ar_ready, 1);

    // single write
    aw_id = 8'h3A; aw_valid = 1'b1;
    cyc();
    aw_valid = 1'b0; aw_id = '0;
    chk("w_ready_n1", w_ready, 0);
    chk("busy_write", busy, 1);
    cyc();
    chk("w_ready_n2", w_ready, 1);
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1; w_last = (i == 3);
      chk("w_ready_beat", w_ready, 1);
      cyc();
    end
    w_valid = 1'b0; w_last = 1'b0;
    chk("b_valid", b_valid, 1);
    chk("b_payload", {b_id, b_resp}, {8'h3A, 2'b10});
    chk("w_ready_resp", w_ready, 0);
    cyc();
    chk("b_hold", {b_valid, b_id, b_resp}, {1'b1, 8'h3A, 2'b10});
    chk("w_cnt_before_b", w_deny_cnt, 0);
    b_ready = 1'b1;
    cyc();
    b_ready = 1'b0;
    chk("b_done", b_valid, 0);
    chk("w_cnt_1", w_deny_cnt, 1);
    chk("busy_after_write", busy, 0);

    // single read
    ar_id = 8'h05; ar_len = 8'd3; ar_valid = 1'b1;
    cyc();
    ar_valid = 1'b0;
    chk("r_valid_n1", r_valid, 0);
    cyc();
    chk("r_valid_n2", r_valid, 1);
    rd_burst(8'h05, 3, 1'b0);
    chk("r_cnt_1", r_deny_cnt, 1);

    // full read FIFO
    ar_valid = 1'b1; ar_len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      ar_id = 8'h40 + 8'(i);
      chk("ar_ready_acc", ar_ready, 1);
      cyc();
    end
    ar_id = 8'h44;
    chk("ar_ready_full", ar_ready, 0);
    cyc();
    cyc();
    chk("ar_ready_still_full", ar_ready, 0);
    chk("full_head", {r_valid, r_id, r_last}, {1'b1, 8'h40, 1'b1});
    r_ready = 1'b1;
    cyc();
    r_ready = 1'b0;
    chk("ar_ready_reassert", ar_ready, 1);
    chk("r_bubble", r_valid, 0);
    cyc();
    ar_valid = 1'b0;
    chk("ar_ready_refull", ar_ready, 0);
    rd_burst(8'h41, 0, 1'b0);
    rd_burst(8'h42, 0, 1'b0);
    rd_burst(8'h43, 0, 1'b0);
    rd_burst(8'h44, 0, 1'b0);
    chk("r_cnt_6", r_deny_cnt, 6);

    // backpressure
    ar_id = 8'h77; ar_len = 8'd7; ar_valid = 1'b1;
    cyc();
    ar_valid = 1'b0;
    rd_burst(8'h77, 7, 1'b1);
    chk("r_cnt_7", r_deny_cnt, 7);

    // longest burst
    ar_id = 8'hA5; ar_len = 8'd255; ar_valid = 1'b1;
    cyc();
    ar_valid = 1'b0;
    rd_burst(8'hA5, 255, 1'b0);
    chk("r_cnt_8", r_deny_cnt, 8);

    // concurrent write and read
    aw_id = 8'h11; aw_valid = 1'b1;
    ar_id = 8'h22; ar_len = 8'd0; ar_valid = 1'b1;
    cyc();
    aw_valid = 1'b0; ar_valid = 1'b0;
    w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    bdone = 0; rdone = 0;
    for (int c = 0; c < 10; c++) begin
      if (b_valid) begin
        chk("cc_b", {b_id, b_resp}, {8'h11, 2'b10});
        bdone++;
        w_valid = 1'b0; w_last = 1'b0;
      end
      if (r_valid) begin
        chk("cc_r", {r_id, r_resp, r_last}, {8'h22, 2'b10, 1'b1});
        rdone++;
      end
      cyc();
    end
    w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    chk("cc_b_once", bdone, 1);
    chk("cc_r_once", rdone, 1);
    chk("cc_counts", {w_deny_cnt, r_deny_cnt}, {16'd2, 16'd9});
    chk("cc_busy", busy, 0);

    // reset during a read burst with a write also pending
    aw_id = 8'h99; aw_valid = 1'b1;
    ar_id = 8'h66; ar_len = 8'd7; ar_valid = 1'b1;
    cyc();
    aw_valid = 1'b0; ar_valid = 1'b0;
    r_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (r_valid) break;
      cyc();
    end
    chk("pre_rst_beat1", r_valid, 1);
    cyc();
    chk("pre_rst_beat2", {r_valid, r_last, r_id}, {1'b1, 1'b0, 8'h66});
    rst = 1'b1;
    #1;
    r_ready = 1'b0;
    chk("mid_rst_valids", {r_valid, w_ready, b_valid}, 0);
    chk("mid_rst_counts", {w_deny_cnt, r_deny_cnt}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_readies", {aw_ready, ar_ready}, 2'b11);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst2_idle", {busy, r_valid, w_ready}, 0);
    chk("post_rst2_readies", {aw_ready, ar_ready}, 2'b11);
    ar_id = 8'h12; ar_len = 8'd2; ar_valid = 1'b1;
    cyc();
    ar_valid = 1'b0;
    rd_burst(8'h12, 2, 1'b0);
    chk("post_rst2_cnt", {w_deny_cnt, r_deny_cnt}, {16'd0, 16'd1});
    cyc();
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
